alu_regfile_core: RTL and testbench

Parametrised register-file ALU datapath: a WIDTH-bit, NREGS-entry register file feeding a multi-cycle ALU under a start/done handshake. Each accepted command reads two source registers, executes one of eight operations, writes the result back to a destination register and reports status flags. It is the next-generation replacement for the fixed 4 × 1-bit register/ALU block, sitting between the lab control sequencer and the register-file display/debug logic.

---
 rtl/alu_regfile_pkg.sv | 24 ++
 rtl/alu_regfile_core_mul.sv | 46 ++++
 rtl/alu_regfile_core.sv | 160 ++++++++++++++++
 tb/tb_alu_regfile_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_regfile_pkg.sv
// alu_regfile_pkg: opcode and FSM state types shared by the register-file ALU
package alu_regfile_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_SHR,
        OP_MUL
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_e;

endpackage

// File: rtl/alu_regfile_core_mul.sv
// alu_mul_serial: unsigned shift-add multiplier, one partial product per cycle, WIDTH cycles
module alu_mul_serial #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;

    // next partial product; on the final step this is the full product, so done and product line up
    always_comb begin
        sum     = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? mcand : {WIDTH{1'b0}})};
        product = {sum, p[WIDTH-1:1]};
        busy    = cnt != '0;
        done    = cnt == CW'(1);
    end

    // load multiplier into the low half, then shift right one step per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p     <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else if (start) begin
            p     <= {{WIDTH{1'b0}}, b};
            mcand <= a;
            cnt   <= CW'(WIDTH);
        end else if (busy) begin
            p     <= product;
            cnt   <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_regfile_core.sv
// alu_regfile_core: register file + multi-cycle ALU with start/done handshake; ALU_MUL_EN enables serial MUL
module alu_regfile_core
    import alu_regfile_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int SELW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SELW-1:0] sel_ri,
    input  logic [SELW-1:0] sel_rj,
    input  logic [SELW-1:0] sel_rk,
    input  logic [OP_W-1:0] sel_op,
    output logic            busy,
    output logic            done,
    output logic [WIDTH-1:0] result,
    output logic            flag_z,
    output logic            flag_c,
    output logic            flag_v,
    output logic            err,
    input  logic [SELW-1:0] rd_sel,
    output logic [WIDTH-1:0] rd_data
);

    state_e           state, state_n;
    op_e              op_q;
    logic [SELW-1:0]  ri_q, rj_q, rk_q;
    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum, dif;
    logic             alu_c, alu_v, alu_err;
    logic             accept, exec_last;

`ifdef ALU_MUL_EN
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_p;

    alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (state == S_READ && op_q == OP_MUL && !mul_busy),
        .a       (rf[ri_q]),
        .b       (rf[rj_q]),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_p)
    );

    assign exec_last = (op_q != OP_MUL) || mul_done;
`else
    assign exec_last = 1'b1;
`endif

    assign rd_data = rf[rd_sel];
    assign accept  = start && (state == S_IDLE || state == S_WB);

    // single-cycle ALU on the latched operands; MUL either takes the multiplier product or is illegal
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        dif     = {1'b0, a_q} - {1'b0, b_q};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif[WIDTH-1:0];
                alu_c   = dif[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                alu_res = mul_p[WIDTH-1:0];
                alu_c   = |mul_p[2*WIDTH-1:WIDTH];
`else
                alu_err = 1'b1;
`endif
            end
        endcase
    end

    // next state and handshake outputs; WB doubles as an idle slot so commands can run back-to-back
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: state_n = start ? S_READ : S_IDLE;
            S_READ: state_n = S_EXEC;
            S_EXEC: state_n = exec_last ? S_WB : S_EXEC;
            S_WB:   state_n = start ? S_READ : S_IDLE;
        endcase
        busy = state == S_READ || state == S_EXEC;
        done = state == S_WB;
    end

    // state register, command capture on accept, operand latch before any writeback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            op_q  <= OP_ADD;
            ri_q  <= '0;
            rj_q  <= '0;
            rk_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q <= op_e'(sel_op);
                ri_q <= sel_ri;
                rj_q <= sel_rj;
                rk_q <= sel_rk;
            end
            if (state == S_READ) begin
                a_q <= rf[ri_q];
                b_q <= rf[rj_q];
            end
        end
    end

    // commit on the edge entering WB so result, flags and the register are valid while done is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= WIDTH'(i);
            result <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
        end else if (state == S_EXEC && exec_last) begin
            err <= alu_err;
            if (!alu_err) begin
                rf[rk_q] <= alu_res;
                result   <= alu_res;
                flag_z   <= alu_res == '0;
                flag_c   <= alu_c;
                flag_v   <= alu_v;
            end
        end
    end

endmodule

// File: tb/tb_alu_regfile_core.sv
// tb_alu_regfile_core: directed vector table plus handshake, reset and MUL sequences (honours ALU_MUL_EN)
module tb_alu_regfile_core;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] sel_ri = '0, sel_rj = '0, sel_rk = '0, rd_sel = '0;
    logic [2:0] sel_op = '0;
    logic       busy, done, flag_z, flag_c, flag_v, err;
    logic [7:0] result, rd_data;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] op;
        logic [1:0] ri, rj, rk;
        logic [7:0] res;
        logic       z, c, v, e;
        logic [7:0] reg_exp;
    } vec_t;

    vec_t vt[14];

    alu_regfile_core #(.WIDTH(8), .NREGS(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sel_ri (sel_ri),
        .sel_rj (sel_rj),
        .sel_rk (sel_rk),
        .sel_op (sel_op),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .err    (err),
        .rd_sel (rd_sel),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] ri, input logic [1:0] rj, input logic [1:0] rk);
        start  = 1'b1;
        sel_op = op;
        sel_ri = ri;
        sel_rj = rj;
        sel_rk = rk;
    endtask

    // counts edges from the accept edge until done is seen; scrambles inputs while busy
    task automatic wait_done(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                start  = 1'b0;
                sel_op = ~sel_op;
                sel_ri = ~sel_ri;
                sel_rj = ~sel_rj;
                sel_rk = ~sel_rk;
            end
        end while (!done && edges < 100);
    endtask

    task automatic read_reg(input logic [1:0] r, input logic [7:0] exp, input string name);
        rd_sel = r;
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic check_out(input string name, input logic [7:0] res, input logic z, input logic c,
                             input logic v, input logic e);
        chk({name, " result"}, result, res);
        chk({name, " flags zcv"}, {flag_z, flag_c, flag_v}, {z, c, v});
        chk({name, " err"}, err, e);
    endtask

    initial begin
        int lat, dones;
        vt[0]  = '{3'd0, 2'd1, 2'd3, 2'd0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04};
        vt[1]  = '{3'd1, 2'd1, 2'd3, 2'd2, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFE};
        vt[2]  = '{3'd4, 2'd3, 2'd3, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[3]  = '{3'd0, 2'd2, 2'd2, 2'd1, 8'hFC, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFC};
        vt[4]  = '{3'd5, 2'd1, 2'd0, 2'd1, 8'hF8, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF8};
        vt[5]  = '{3'd6, 2'd2, 2'd0, 2'd3, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F};
        vt[6]  = '{3'd6, 2'd3, 2'd0, 2'd0, 8'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3F};
        vt[7]  = '{3'd0, 2'd3, 2'd3, 2'd1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFE};
        vt[8]  = '{3'd1, 2'd1, 2'd3, 2'd0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7F};
        vt[9]  = '{3'd2, 2'd0, 2'd1, 2'd2, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7E};
        vt[10] = '{3'd1, 2'd0, 2'd3, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[11] = '{3'd0, 2'd1, 2'd2, 2'd3, 8'h7C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7C};
        vt[12] = '{3'd5, 2'd0, 2'd0, 2'd0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE};
        vt[13] = '{3'd3, 2'd0, 2'd3, 2'd2, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE};

        // reset state
        do_reset();
        for (int r = 0; r < 4; r++) read_reg(2'(r), 8'(r), $sformatf("reset R%0d", r));
        chk("reset busy/done", {busy, done}, 2'b00);
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // vector table, one command at a time from idle
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].op, vt[i].ri, vt[i].rj, vt[i].rk);
            wait_done(lat);
            chk($sformatf("v%0d latency", i), lat, 3);
            check_out($sformatf("v%0d", i), vt[i].res, vt[i].z, vt[i].c, vt[i].v, vt[i].e);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d busy/done after", i), {busy, done}, 2'b00);
            read_reg(vt[i].rk, vt[i].reg_exp, $sformatf("v%0d reg", i));
        end

        // start during busy is ignored: exactly one done, no stray write
        do_reset();
        drive(3'd4, 2'd3, 2'd3, 2'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ignore busy after accept", busy, 1'b1);
        dones = 0;
        @(negedge clk);
        drive(3'd0, 2'd1, 2'd2, 2'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (done) dones++;
        end
        chk("ignore done count", dones, 1);
        check_out("ignore", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        read_reg(2'd3, 8'h00, "ignore R3");
        read_reg(2'd0, 8'h00, "ignore R0");

        // back-to-back: second start held in the done cycle, reads the just-written register
        drive(3'd0, 2'd1, 2'd2, 2'd0);
        wait_done(lat);
        chk("b2b first latency", lat, 3);
        chk("b2b first result", result, 8'h03);
        drive(3'd1, 2'd0, 2'd1, 2'd1);
        wait_done(lat);
        chk("b2b second latency", lat, 3);
        check_out("b2b second", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        read_reg(2'd1, 8'h02, "b2b R1");
        read_reg(2'd0, 8'h03, "b2b R0");

        // MUL: enabled -> serial multiply; disabled -> illegal, nothing written, outputs held
        do_reset();
        drive(3'd0, 2'd3, 2'd3, 2'd2);
        wait_done(lat);
        chk("mul setup result", result, 8'h06);
        @(posedge clk);
        #1;
        drive(3'd7, 2'd2, 2'd2, 2'd1);
        wait_done(lat);
        chk("mul1 latency", lat, MUL_EN ? 10 : 3);
        check_out("mul1", MUL_EN ? 8'h24 : 8'h06, 1'b0, 1'b0, 1'b0, !MUL_EN);
        @(posedge clk);
        #1;
        read_reg(2'd1, MUL_EN ? 8'h24 : 8'h01, "mul1 R1");
        drive(3'd7, 2'd1, 2'd1, 2'd0);
        wait_done(lat);
        chk("mul2 latency", lat, MUL_EN ? 10 : 3);
        check_out("mul2", MUL_EN ? 8'h10 : 8'h06, 1'b0, MUL_EN, 1'b0, !MUL_EN);
        @(posedge clk);
        #1;
        read_reg(2'd0, MUL_EN ? 8'h10 : 8'h00, "mul2 R0");

        // reset asserted during EXEC discards the command
        drive(3'd0, 2'd1, 2'd1, 2'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst-exec busy before", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst-exec busy/done", {busy, done}, 2'b00);
        check_out("rst-exec", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("rst-exec no done", dones, 0);
        read_reg(2'd0, 8'h00, "rst-exec R0");
        drive(3'd0, 2'd1, 2'd1, 2'd0);
        wait_done(lat);
        chk("post-rst latency", lat, 3);
        chk("post-rst result", result, 8'h02);
        @(posedge clk);
        #1;
        read_reg(2'd0, 8'h02, "post-rst R0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
